// File: rtl/ram32x4_arbiter.sv
// Two-requester round-robin front end for a 32x4 synchronous RAM.
// Zero-fills the RAM after reset or on clr, then serves one access per two cycles.
module ram32x4_arbiter #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 4,
    parameter int unsigned DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic              init_done,
    output logic              ram_en,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_GRANT
    } state_t;

    localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              prio_q, prio_d;
    logic              ram_en_q, ram_en_d;
    logic              ram_wen_q, ram_wen_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_din_q, ram_din_d;
    logic              gnt0_q, gnt0_d;
    logic              gnt1_q, gnt1_d;
    logic              init_done_q, init_done_d;
    logic [1:0]        rd_pend_q, rd_pend_d;
    logic              rvalid0_q, rvalid0_d;
    logic              rvalid1_q, rvalid1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              pick1;

    // prio_q=1 means requester 1 wins a tie
    assign pick1 = req1 && (!req0 || prio_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        prio_d      = prio_q;
        ram_en_d    = 1'b0;
        ram_wen_d   = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_din_d   = ram_din_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        init_done_d = init_done_q;

        // Read return: RAM samples during the grant cycle, data is captured one cycle later
        rd_pend_d = {gnt1_q & ~ram_wen_q, gnt0_q & ~ram_wen_q};
        rvalid0_d = rd_pend_q[0];
        rvalid1_d = rd_pend_q[1];
        rdata0_d  = rd_pend_q[0] ? ram_dout : rdata0_q;
        rdata1_d  = rd_pend_q[1] ? ram_dout : rdata1_q;

        unique case (state_q)
            ST_CLEAR: begin
                ram_en_d    = 1'b1;
                ram_wen_d   = 1'b1;
                ram_addr_d  = cnt_q;
                ram_din_d   = '0;
                init_done_d = 1'b0;
                cnt_d       = cnt_q + ADDR_W'(1);
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                // init_done rises the cycle after the last fill write is on the bus
                init_done_d = 1'b1;
                if (clr) begin
                    state_d     = ST_CLEAR;
                    cnt_d       = '0;
                    init_done_d = 1'b0;
                end else if (req0 || req1) begin
                    ram_en_d = 1'b1;
                    state_d  = ST_GRANT;
                    if (pick1) begin
                        ram_wen_d  = we1;
                        ram_addr_d = addr1;
                        ram_din_d  = wdata1;
                        gnt1_d     = 1'b1;
                        prio_d     = 1'b0;
                    end else begin
                        ram_wen_d  = we0;
                        ram_addr_d = addr0;
                        ram_din_d  = wdata0;
                        gnt0_d     = 1'b1;
                        prio_d     = 1'b1;
                    end
                end
            end
            ST_GRANT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_CLEAR;
            cnt_q       <= '0;
            prio_q      <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_wen_q   <= 1'b0;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            init_done_q <= 1'b0;
            rd_pend_q   <= '0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prio_q      <= prio_d;
            ram_en_q    <= ram_en_d;
            ram_wen_q   <= ram_wen_d;
            ram_addr_q  <= ram_addr_d;
            ram_din_q   <= ram_din_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            init_done_q <= init_done_d;
            rd_pend_q   <= rd_pend_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign rvalid0   = rvalid0_q;
    assign rvalid1   = rvalid1_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign init_done = init_done_q;
    assign ram_en    = ram_en_q;
    assign ram_wen   = ram_wen_q;
    assign ram_addr  = ram_addr_q;
    assign ram_din   = ram_din_q;

    a_gnt_onehot : assert property (@(posedge clk) disable iff (rst) !(gnt0_q && gnt1_q));
    a_gnt_has_en : assert property (@(posedge clk) disable iff (rst) (gnt0_q || gnt1_q) |-> ram_en_q);

endmodule

// File: tb/tb_ram32x4_arbiter.sv
// Directed bench for ram32x4_arbiter with a behavioural 32x4 RAM attached.
module tb_ram32x4_arbiter;

    logic       clk = 1'b0;
    logic       rst, clr;
    logic       req0, we0, req1, we1;
    logic [4:0] addr0, addr1;
    logic [3:0] wdata0, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1, init_done;
    logic [3:0] rdata0, rdata1;
    logic       ram_en, ram_wen;
    logic [4:0] ram_addr;
    logic [3:0] ram_din;
    logic [3:0] ram_dout = 4'h0;

    always #5 clk = ~clk;

    ram32x4_arbiter #(.ADDR_W(5), .DATA_W(4), .DEPTH(32)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .init_done(init_done),
        .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    // RAM seeded with 4'hF so that the zero-fill is observable
    logic [3:0] mem [32];
    logic       mem_seeded = 1'b0;
    always @(posedge clk) begin
        if (!mem_seeded) begin
            for (int i = 0; i < 32; i++) mem[i] <= 4'hF;
            mem_seeded <= 1'b1;
        end else if (ram_en) begin
            if (ram_wen) mem[ram_addr] <= ram_din;
            else         ram_dout <= mem[ram_addr];
        end
    end

    typedef struct {
        logic       who;
        logic       we;
        logic [4:0] addr;
        logic [3:0] wdata;
        logic [3:0] exp_rd;
    } vec_t;

    typedef struct {
        logic [3:0] flags;   // {gnt0, gnt1, rvalid0, rvalid1}
        logic [7:0] rd;      // {rdata0, rdata1}
    } alt_t;

    int         n_vec = 0;
    int         n_bad = 0;
    logic [3:0] mdl_rd [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_gnt(input logic who, input string name);
        int waits = 0;
        while (waits < 40) begin
            @(negedge clk);
            waits++;
            if (who ? gnt1 : gnt0) break;
        end
        chk($sformatf("%s_gnt_latency", name), 32'(waits), 32'd1);
        chk($sformatf("%s_other_gnt", name), 32'(who ? gnt0 : gnt1), 32'd0);
    endtask

    task automatic check_fill(input string name);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            chk($sformatf("%s_a%0d", name, i),
                32'({init_done, ram_en, ram_wen, ram_addr, ram_din, gnt0, gnt1}),
                32'({1'b0, 1'b1, 1'b1, 5'(i), 4'h0, 1'b0, 1'b0}));
        end
    endtask

    task automatic do_acc(input vec_t v, input string nm);
        logic [1:0] exp_rv;
        exp_rv = v.we ? 2'b00 : (v.who ? 2'b10 : 2'b01);
        if (!v.who) begin
            req0 = 1'b1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata;
        end else begin
            req1 = 1'b1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata;
        end
        wait_gnt(v.who, nm);
        req0 = 1'b0;
        req1 = 1'b0;
        chk($sformatf("%s_bus", nm),
            32'({ram_en, ram_wen, ram_addr, v.we ? ram_din : 4'h0}),
            32'({1'b1, v.we, v.addr, v.we ? v.wdata : 4'h0}));
        @(negedge clk);
        chk($sformatf("%s_t1", nm), 32'({rvalid0, rvalid1, gnt0, gnt1}), 32'd0);
        @(negedge clk);
        if (!v.we) mdl_rd[v.who] = v.exp_rd;
        chk($sformatf("%s_rvalid", nm), 32'({rvalid1, rvalid0}), 32'(exp_rv));
        chk($sformatf("%s_rdata", nm), 32'({rdata1, rdata0}), 32'({mdl_rd[1], mdl_rd[0]}));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs [12];
        alt_t alt [9];
        vec_t v;

        vecs[0]  = '{1'b0, 1'b0, 5'd5,  4'h0, 4'h0};
        vecs[1]  = '{1'b0, 1'b1, 5'd5,  4'hA, 4'h0};
        vecs[2]  = '{1'b0, 1'b0, 5'd5,  4'h0, 4'hA};
        vecs[3]  = '{1'b1, 1'b0, 5'd5,  4'h0, 4'hA};
        vecs[4]  = '{1'b1, 1'b1, 5'd31, 4'hC, 4'h0};
        vecs[5]  = '{1'b0, 1'b1, 5'd0,  4'h3, 4'h0};
        vecs[6]  = '{1'b0, 1'b0, 5'd31, 4'h0, 4'hC};
        vecs[7]  = '{1'b1, 1'b0, 5'd0,  4'h0, 4'h3};
        vecs[8]  = '{1'b1, 1'b1, 5'd7,  4'h5, 4'h0};
        vecs[9]  = '{1'b0, 1'b1, 5'd3,  4'h9, 4'h0};
        vecs[10] = '{1'b1, 1'b0, 5'd7,  4'h0, 4'h5};
        vecs[11] = '{1'b1, 1'b0, 5'd31, 4'h0, 4'hC};

        alt[0] = '{4'b1000, 8'hCC};
        alt[1] = '{4'b0000, 8'hCC};
        alt[2] = '{4'b0110, 8'h9C};
        alt[3] = '{4'b0000, 8'h9C};
        alt[4] = '{4'b1001, 8'h95};
        alt[5] = '{4'b0000, 8'h95};
        alt[6] = '{4'b0110, 8'h95};
        alt[7] = '{4'b0000, 8'h95};
        alt[8] = '{4'b0001, 8'h95};

        rst = 1'b1; clr = 1'b0;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        mdl_rd[0] = 4'h0;
        mdl_rd[1] = 4'h0;

        // Reset state and first zero-fill
        repeat (3) @(negedge clk);
        chk("reset_outs",
            32'({ram_en, ram_wen, ram_addr, ram_din, gnt0, gnt1, rvalid0, rvalid1,
                 rdata0, rdata1, init_done}), 32'd0);
        rst = 1'b0;
        check_fill("fill_rst");
        @(negedge clk);
        chk("init_done_up", 32'({init_done, ram_en, ram_wen, gnt0, gnt1}), 32'b10000);

        for (int i = 0; i < 12; i++) do_acc(vecs[i], $sformatf("vec%0d", i));

        // Both requesters held: grants alternate, starting with requester 0
        req0 = 1'b1; we0 = 1'b0; addr0 = 5'd3;
        req1 = 1'b1; we1 = 1'b0; addr1 = 5'd7;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (c == 7) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            chk($sformatf("alt_c%0d_flags", c + 1), 32'({gnt0, gnt1, rvalid0, rvalid1}), 32'(alt[c].flags));
            chk($sformatf("alt_c%0d_rdata", c + 1), 32'({rdata0, rdata1}), 32'(alt[c].rd));
        end
        mdl_rd[0] = 4'h9;
        mdl_rd[1] = 4'h5;

        // clr wins over a simultaneous request, then the read sees zero
        v = '{1'b0, 1'b1, 5'd9, 4'h6, 4'h0};
        do_acc(v, "wr9");
        clr = 1'b1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 5'd9;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_entry", 32'({init_done, ram_en, gnt0, gnt1}), 32'd0);
        check_fill("fill_clr");
        @(negedge clk);
        chk("clr_then_gnt0", 32'({init_done, gnt0, gnt1, ram_en, ram_wen, ram_addr}),
            32'({1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd9}));
        req0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("clr_rd9", 32'({rvalid1, rvalid0, rdata0}), 32'({2'b01, 4'h0}));
        mdl_rd[0] = 4'h0;

        // Reset one cycle after a read grant; req1 held through reset and fill
        v = '{1'b0, 1'b1, 5'd2, 4'hF, 4'h0};
        do_acc(v, "wr2");
        req0 = 1'b1; we0 = 1'b0; addr0 = 5'd2;
        wait_gnt(1'b0, "rd2");
        req0 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        req1 = 1'b1; we1 = 1'b0; addr1 = 5'd7;
        @(negedge clk);
        chk("midrst_outs",
            32'({ram_en, ram_wen, ram_addr, ram_din, gnt0, gnt1, rvalid0, rvalid1,
                 rdata0, rdata1, init_done}), 32'd0);
        rst = 1'b0;
        check_fill("fill_rst2");
        @(negedge clk);
        chk("held_gnt1", 32'({init_done, gnt1, gnt0, ram_en, ram_wen, ram_addr}),
            32'({1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd7}));
        req1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("held_rd7", 32'({rvalid1, rvalid0, rdata1, rdata0}), 32'({2'b10, 4'h0, 4'h0}));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ram32x4_arbiter.md
Name: ram32x4_arbiter

Overview:
Round-robin arbiter and sequencer sharing one ram32x4 (32 words x 4 bits, synchronous write, one-cycle registered read) between two requesters. It drives the RAM's enable/wen/address/data_in and steers the returned read data to the owning requester. After reset, or on command, it zero-fills the whole RAM before granting any access.

Parameters:
ADDR_W, 5, RAM address width
DATA_W, 4, RAM data width
DEPTH, 32, words cleared by the zero-fill sequence (equals 2**ADDR_W)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
clr  in  1  request a full zero-fill of the RAM (sampled in IDLE)
req0  in  1  requester 0 access request
we0  in  1  requester 0 write (1) / read (0)
addr0  in  ADDR_W  requester 0 address
wdata0  in  DATA_W  requester 0 write data
gnt0  out  1  requester 0 grant pulse
rvalid0  out  1  requester 0 read-data-valid pulse
rdata0  out  DATA_W  requester 0 read data
req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as requester 0, for requester 1
init_done  out  1  high when no zero-fill is in progress
ram_en  out  1  to RAM enable
ram_wen  out  1  to RAM wen
ram_addr  out  ADDR_W  to RAM address
ram_din  out  DATA_W  to RAM data_in
ram_dout  in  DATA_W  from RAM data_out

Behaviour:
- All outputs registered. Reset values: all outputs 0; state CLEAR; clear counter 0; round-robin pointer favours requester 0.
- States: CLEAR, IDLE, GRANT.
- CLEAR: each cycle ram_en=1, ram_wen=1, ram_addr=cnt, ram_din=0; cnt increments. After the write at cnt=DEPTH-1, go to IDLE with init_done=1. Occupies exactly DEPTH cycles. gnt*=0 throughout. Requests are not sampled and are not lost: a held req is serviced afterwards.
- IDLE: ram_en=0, ram_wen=0. At the clock edge:
  - if clr=1, go to CLEAR (cnt=0, init_done=0). clr has priority over requests.
  - else if any req, pick the winner, register its we/addr/wdata onto ram_wen/ram_addr/ram_din, set ram_en=1 and that gnt=1, and go to GRANT.
- Arbitration:
  - a lone requester always wins;
  - on a tie, the requester not granted most recently wins;
  - the pointer updates only on a grant.
- GRANT: lasts exactly one cycle. The RAM access and gnt_i are active. No sampling occurs. Return to IDLE; ram_en, ram_wen and gnt drop.
- Requester rule: hold req/we/addr/wdata stable until gnt is seen, then deassert req by the next edge. A req still high in the following IDLE cycle is a new request.
- Read return:
  - read granted in cycle T;
  - RAM output valid in T+1 and captured into rdata_i at the end of T+1;
  - rvalid_i=1 for exactly cycle T+2.
  - rdata_i holds its value until that requester's next read completes.
  - The other requester's rdata/rvalid are unaffected.
- Writes produce no rvalid.
- Maximum throughput is one access per 2 cycles. A new grant at T+2 may coincide with a previous rvalid; both are legal.
- rst mid-access: any pending rvalid is cancelled, all outputs clear, and zero-fill restarts from address 0.
- clr asserted while in GRANT or CLEAR is ignored; it must still be high in an IDLE cycle to take effect.

Test Plan:
- Reset, no requests -> init_done=0 for 32 cycles with ram_wen=1, ram_din=0, ram_addr 0..31 in order; then init_done=1; any read returns 4'h0.
- req0 write addr=5 data=4'hA, then req0 read addr=5 -> gnt0 one cycle after sampling; rvalid0 two cycles after the read grant with rdata0=4'hA; gnt1/rvalid1 stay 0.
- req0 and req1 held continuously (reads of addr 3 / 7) -> grants alternate 0,1,0,1 with one access per 2 cycles; each rvalid carries the correct owner's data.
- req1 asserted during CLEAR -> no gnt1 until init_done=1; then gnt1 in the first GRANT cycle.
- Write addr=9 data=4'h6, then clr=1 in IDLE with req0 also high -> CLEAR wins for 32 cycles; afterwards req0 read of addr 9 returns 4'h0.
- rst asserted in the cycle after a read GRANT -> no rvalid appears; outputs are 0 and zero-fill restarts at addr 0.
